// File: rtl/uart_menu_host.sv
// Host end of the menu-over-UART link. It waits for the device line to go quiet, sends the
// ASCII selection byte, then collects the reply until the line is quiet again.
module uart_menu_host #(
  parameter int unsigned CLK_DIV   = 54,
  parameter int unsigned IDLE_BITS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] sel,
  input  logic       dev_tx,
  output logic       host_tx,
  output logic       busy,
  output logic       done,
  output logic [9:0] rx_byte_count,
  output logic [7:0] rx_xor,
  output logic [7:0] last_byte,
  output logic       frame_err
);

  localparam int unsigned DivW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned QuietMax = IDLE_BITS * 16;
  localparam int unsigned QuietW   = $clog2(QuietMax + 1);

  typedef enum logic [2:0] {StIdle, StQuiet, StSend, StResp, StDone} state_e;

  logic [DivW-1:0]   div_q;
  logic              tick;
  logic [1:0]        sync_q;
  logic              rxd;
  logic              rx_prev_q;
  logic              rx_busy_q;
  logic [3:0]        rx_cnt_q;
  logic [3:0]        rx_bit_q;
  logic [7:0]        rx_shift_q;
  logic              rx_valid_q;
  logic              rx_ferr_q;
  state_e            state_q;
  logic [2:0]        sel_q;
  logic [3:0]        tx_cnt_q;
  logic [3:0]        tx_bit_q;
  logic [9:0]        tx_frame;
  logic [QuietW-1:0] quiet_q;
  logic              quiet;

  assign tick     = (div_q == DivW'(CLK_DIV - 1));
  assign rxd      = sync_q[1];
  assign quiet    = (quiet_q == QuietW'(QuietMax));
  // {stop, '0'+sel, start}, shifted out LSB first
  assign tx_frame = {1'b1, 4'h3, 1'b0, sel_q, 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      div_q     <= tick ? '0 : div_q + DivW'(1);
      sync_q    <= {sync_q[0], dev_tx};
      rx_prev_q <= rxd;
    end
  end

  // 16x oversampling receiver; runs regardless of the host FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_busy_q  <= 1'b0;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (!rx_busy_q) begin
        if (rx_prev_q && !rxd) begin
          rx_busy_q <= 1'b1;
          rx_cnt_q  <= '0;
          rx_bit_q  <= '0;
        end
      end else if (tick) begin
        if (rx_bit_q == 4'd0) begin
          if (rx_cnt_q == 4'd7) begin
            if (rxd) begin
              rx_busy_q <= 1'b0;  // glitch, not a start bit
            end else begin
              rx_bit_q <= 4'd1;
              rx_cnt_q <= '0;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 4'd1;
          end
        end else if (rx_cnt_q == 4'd15) begin
          rx_cnt_q <= '0;
          if (rx_bit_q == 4'd9) begin
            rx_busy_q  <= 1'b0;
            rx_valid_q <= 1'b1;
            rx_ferr_q  <= ~rxd;
          end else begin
            rx_shift_q <= {rxd, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 4'd1;
          end
        end else begin
          rx_cnt_q <= rx_cnt_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      sel_q         <= '0;
      tx_cnt_q      <= '0;
      tx_bit_q      <= '0;
      quiet_q       <= '0;
      host_tx       <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      rx_byte_count <= '0;
      rx_xor        <= '0;
      last_byte     <= '0;
      frame_err     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (rx_busy_q || !rxd) begin
        quiet_q <= '0;
      end else if (tick && !quiet) begin
        quiet_q <= quiet_q + QuietW'(1);
      end
      case (state_q)
        StIdle: begin
          if (start) begin
            sel_q         <= sel;
            rx_byte_count <= '0;
            rx_xor        <= '0;
            last_byte     <= '0;
            frame_err     <= 1'b0;
            quiet_q       <= '0;
            busy          <= 1'b1;
            state_q       <= StQuiet;
          end
        end
        StQuiet: begin
          if (quiet) begin
            host_tx  <= 1'b0;
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            state_q  <= StSend;
          end
        end
        StSend: begin
          if (tick) begin
            if (tx_cnt_q == 4'd15) begin
              tx_cnt_q <= '0;
              if (tx_bit_q == 4'd9) begin
                quiet_q <= '0;
                state_q <= StResp;
              end else begin
                tx_bit_q <= tx_bit_q + 4'd1;
                host_tx  <= tx_frame[tx_bit_q + 4'd1];
              end
            end else begin
              tx_cnt_q <= tx_cnt_q + 4'd1;
            end
          end
        end
        StResp: begin
          if (rx_valid_q) begin
            if (rx_ferr_q) begin
              frame_err <= 1'b1;
            end else begin
              if (rx_byte_count != 10'h3FF) rx_byte_count <= rx_byte_count + 10'd1;
              rx_xor    <= rx_xor ^ rx_shift_q;
              last_byte <= rx_shift_q;
            end
          end
          if (quiet) state_q <= StDone;
        end
        StDone: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_menu_host.sv
// Directed bench for uart_menu_host with a shortened bit time (CLK_DIV=4, IDLE_BITS=4).
module tb_uart_menu_host;

  localparam int unsigned ClkDiv   = 4;
  localparam int unsigned IdleBits = 4;
  localparam int          BitClk   = 16 * ClkDiv;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] sel;
  logic       dev_tx;
  logic       host_tx;
  logic       busy;
  logic       done;
  logic [9:0] rx_byte_count;
  logic [7:0] rx_xor;
  logic [7:0] last_byte;
  logic       frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int host_falls = 0;

  uart_menu_host #(
    .CLK_DIV  (ClkDiv),
    .IDLE_BITS(IdleBits)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .sel          (sel),
    .dev_tx       (dev_tx),
    .host_tx      (host_tx),
    .busy         (busy),
    .done         (done),
    .rx_byte_count(rx_byte_count),
    .rx_xor       (rx_xor),
    .last_byte    (last_byte),
    .frame_err    (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;
  always @(negedge host_tx) host_falls++;

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [2:0] s);
    sel   = s;
    start = 1'b1;
    clocks(1);
    start = 1'b0;
  endtask

  task automatic wait_host_fall(input int budget, output int waited);
    int i = 0;
    waited = -1;
    while (waited < 0 && i < budget) begin
      clocks(1);
      i++;
      if (host_tx === 1'b0) waited = i;
    end
  endtask

  task automatic wait_done(input int budget, output int waited);
    int i = 0;
    waited = -1;
    while (waited < 0 && i < budget) begin
      clocks(1);
      i++;
      if (done === 1'b1) waited = i;
    end
  endtask

  // Called right after the start-bit fall is seen; samples every bit near its middle.
  task automatic capture_frame(output logic [9:0] bits);
    clocks(BitClk / 2);
    bits[0] = host_tx;
    for (int i = 1; i < 10; i++) begin
      clocks(BitClk);
      bits[i] = host_tx;
    end
  endtask

  task automatic dev_send(input logic [7:0] b, input logic stop_ok);
    dev_tx = 1'b0;
    clocks(BitClk);
    for (int i = 0; i < 8; i++) begin
      dev_tx = b[i];
      clocks(BitClk);
    end
    dev_tx = stop_ok;
    clocks(BitClk);
    dev_tx = 1'b1;
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    start  = 1'b0;
    sel    = '0;
    dev_tx = 1'b1;
    clocks(3);
    n_cmp++;
    if (host_tx !== 1'b1) begin n_bad++; $display("FAIL reset_host_tx: got %b want 1", host_tx); end
    n_cmp++;
    if ({busy, done, frame_err, rx_byte_count, rx_xor, last_byte} !== 29'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b ferr=%b cnt=%0d xor=%h last=%h want all 0",
               busy, done, frame_err, rx_byte_count, rx_xor, last_byte);
    end
    rst_n = 1'b1;
    clocks(3);
    n_cmp++;
    if ({host_tx, busy, done} !== 3'b100) begin
      n_bad++;
      $display("FAIL post_reset_idle: got tx/busy/done=%b want 100", {host_tx, busy, done});
    end
  endtask

  task automatic test_select3;
    int w;
    logic [9:0] f;
    start_op(3'd3);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL sel3_busy: got %b want 1", busy); end
    wait_host_fall(400, w);
    n_cmp++;
    if (w < 250 || w > 266) begin
      n_bad++;
      $display("FAIL sel3_quiet_wait: got %0d clocks want 250..266", w);
    end
    capture_frame(f);
    n_cmp++;
    if (f[0] !== 1'b0) begin n_bad++; $display("FAIL sel3_start_bit: got %b want 0", f[0]); end
    n_cmp++;
    if (f[8:1] !== 8'h33) begin n_bad++; $display("FAIL sel3_byte: got %h want 33", f[8:1]); end
    n_cmp++;
    if (f[9] !== 1'b1) begin n_bad++; $display("FAIL sel3_stop_bit: got %b want 1", f[9]); end
  endtask

  task automatic test_three_byte_reply;
    int w;
    int d0;
    clocks(48);
    dev_send(8'h41, 1'b1);
    dev_send(8'h42, 1'b1);
    dev_send(8'h43, 1'b1);
    d0 = done_cnt;
    wait_done(400, w);
    n_cmp++;
    if (w < 200 || w > 260) begin
      n_bad++;
      $display("FAIL reply_done_delay: got %0d clocks want 200..260", w);
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reply_busy_at_done: got %b want 0", busy); end
    clocks(1);
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL reply_done_width: got %b want 0", done); end
    clocks(3);
    n_cmp++;
    if (done_cnt - d0 !== 1) begin
      n_bad++;
      $display("FAIL reply_done_pulses: got %0d want 1", done_cnt - d0);
    end
    n_cmp++;
    if (rx_byte_count !== 10'd3) begin
      n_bad++; $display("FAIL reply_count: got %0d want 3", rx_byte_count);
    end
    n_cmp++;
    if (rx_xor !== 8'h40) begin n_bad++; $display("FAIL reply_xor: got %h want 40", rx_xor); end
    n_cmp++;
    if (last_byte !== 8'h43) begin n_bad++; $display("FAIL reply_last: got %h want 43", last_byte); end
    n_cmp++;
    if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reply_ferr: got %b want 0", frame_err); end
  endtask

  task automatic test_framing_error;
    int w;
    logic [9:0] f;
    start_op(3'd2);
    wait_host_fall(400, w);
    capture_frame(f);
    n_cmp++;
    if (f[8:1] !== 8'h32) begin n_bad++; $display("FAIL ferr_sel_byte: got %h want 32", f[8:1]); end
    clocks(48);
    dev_send(8'h55, 1'b0);
    clocks(BitClk);
    dev_send(8'h10, 1'b1);
    wait_done(400, w);
    n_cmp++;
    if (w < 0) begin n_bad++; $display("FAIL ferr_done: got timeout want done pulse"); end
    n_cmp++;
    if (frame_err !== 1'b1) begin n_bad++; $display("FAIL ferr_flag: got %b want 1", frame_err); end
    n_cmp++;
    if (rx_byte_count !== 10'd1) begin
      n_bad++; $display("FAIL ferr_count: got %0d want 1", rx_byte_count);
    end
    n_cmp++;
    if (rx_xor !== 8'h10) begin n_bad++; $display("FAIL ferr_xor: got %h want 10", rx_xor); end
    n_cmp++;
    if (last_byte !== 8'h10) begin n_bad++; $display("FAIL ferr_last: got %h want 10", last_byte); end
  endtask

  task automatic test_ignored_start_empty;
    int w;
    int falls0;
    logic [9:0] f;
    start_op(3'd1);
    wait_host_fall(400, w);
    capture_frame(f);
    n_cmp++;
    if (f[8:1] !== 8'h31) begin n_bad++; $display("FAIL empty_sel_byte: got %h want 31", f[8:1]); end
    clocks(48);
    falls0 = host_falls;
    start_op(3'd5);
    clocks(10);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL ignored_start_busy: got %b want 1", busy); end
    wait_done(500, w);
    n_cmp++;
    if (w < 0) begin n_bad++; $display("FAIL empty_done: got timeout want done pulse"); end
    n_cmp++;
    if (rx_byte_count !== 10'd0) begin
      n_bad++; $display("FAIL empty_count: got %0d want 0", rx_byte_count);
    end
    n_cmp++;
    if (rx_xor !== 8'h00) begin n_bad++; $display("FAIL empty_xor: got %h want 00", rx_xor); end
    n_cmp++;
    if ({frame_err, last_byte} !== 9'd0) begin
      n_bad++;
      $display("FAIL empty_cleared: got ferr=%b last=%h want 0/00", frame_err, last_byte);
    end
    clocks(400);
    n_cmp++;
    if (host_falls !== falls0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ignored_start_queued: got falls=%0d busy=%b want falls=%0d busy=0",
               host_falls, busy, falls0);
    end
  endtask

  task automatic test_busy_line_deferral;
    int w;
    int falls0;
    logic [7:0] b;
    logic [9:0] f;
    start_op(3'd7);
    falls0 = host_falls;
    for (int i = 0; i < 50; i++) begin
      b = 8'hA5 ^ 8'(i);
      dev_send(b, 1'b1);
    end
    n_cmp++;
    if (host_falls !== falls0 || host_tx !== 1'b1) begin
      n_bad++;
      $display("FAIL defer_tx_quiet: got falls=%0d tx=%b want falls=%0d tx=1",
               host_falls, host_tx, falls0);
    end
    wait_host_fall(400, w);
    n_cmp++;
    if (w < 200 || w > 260) begin
      n_bad++;
      $display("FAIL defer_gap: got %0d clocks want 200..260", w);
    end
    capture_frame(f);
    n_cmp++;
    if (f[8:1] !== 8'h37) begin n_bad++; $display("FAIL defer_byte: got %h want 37", f[8:1]); end
    wait_done(600, w);
    n_cmp++;
    if (w < 0 || rx_byte_count !== 10'd0) begin
      n_bad++;
      $display("FAIL defer_result: got wait=%0d cnt=%0d want done and cnt 0", w, rx_byte_count);
    end
  endtask

  task automatic test_reset_mid_send;
    int w;
    int falls0;
    start_op(3'd4);
    wait_host_fall(400, w);
    clocks(10);
    n_cmp++;
    if (host_tx !== 1'b0) begin n_bad++; $display("FAIL midsend_in_start: got %b want 0", host_tx); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (host_tx !== 1'b1) begin n_bad++; $display("FAIL midsend_async_tx: got %b want 1", host_tx); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL midsend_async_busy: got %b want 0", busy); end
    clocks(2);
    rst_n  = 1'b1;
    falls0 = host_falls;
    clocks(400);
    n_cmp++;
    if (host_falls !== falls0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midsend_after_reset: got falls=%0d busy=%b want falls=%0d busy=0",
               host_falls, busy, falls0);
    end
  endtask

  initial begin
    test_reset();
    test_select3();
    test_three_byte_reply();
    test_framing_error();
    test_ignored_start_empty();
    test_busy_line_deferral();
    test_reset_mid_send();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_menu_host.md
# uart_menu_host

Host-side serial initiator for the menu-over-UART device. On a `start` request it waits for the device's serial stream to go quiet, transmits a one-character selection byte, collects the device's reply until the line goes quiet again, and reports byte count, XOR checksum, last byte and framing status. It contains its own baud tick generator, 8N1 transmitter and 16x-oversampling receiver. It is used as the bench or companion-chip end of the menu protocol.

## Interface
Parameters:
- `CLK_DIV`, 54: clocks per 16x oversampling tick. One bit lasts 16*CLK_DIV clocks.
- `IDLE_BITS`, 20: quiet-line duration, in bit times, that ends a wait or a reply.

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle request. Accepted only in IDLE.
- `sel`  in  3  selection. The transmitted byte is 0x30+sel (ASCII '0'..'7'). It is sampled when `start` is accepted.
- `dev_tx`  in  1  serial line from the device. Idle high.
- `host_tx`  out  1  serial line to the device. Idle high.
- `busy`  out  1  high from `start` acceptance until `done`.
- `done`  out  1  one-cycle pulse when the reply is complete.
- `rx_byte_count`  out  10  reply bytes received. Saturates at 1023.
- `rx_xor`  out  8  XOR of all valid reply bytes.
- `last_byte`  out  8  most recent valid reply byte.
- `frame_err`  out  1  sticky. Set when any reply byte has its stop bit sampled low.

## Operation
- Reset values:
  - `host_tx`=1.
  - `busy`, `done`, `frame_err`=0.
  - `rx_byte_count`, `rx_xor`, `last_byte`=0.
  - FSM=IDLE, tick divider=0, synchronizer flops=1.
- `dev_tx` passes through a 2-flop synchronizer before use.
- Tick generator: free-running counter 0..CLK_DIV-1. `tick` is asserted for one clock when the counter equals CLK_DIV-1.
- Frame format: 8N1, LSB first, 16 ticks per bit, stop bit lasts 16 ticks.
- RX:
  - A falling edge while idle starts a frame.
  - The start bit is re-checked at tick 7; if the line is high, the frame is abandoned silently.
  - Data bits are sampled every 16 ticks after that point, followed by the stop bit.
- RX runs in every FSM state. Bytes are only accounted in RESP.
- Quiet counter:
  - Counts ticks while the RX is idle and the synchronized line is high.
  - Clears on any RX activity.
  - `quiet` = counter reached IDLE_BITS*16. The counter saturates there.
- FSM:
  - IDLE:
    - `start`=1 → latch `sel`.
    - Clear `rx_byte_count`, `rx_xor`, `last_byte`, `frame_err`.
    - Clear the quiet counter, set `busy`, go to QUIET.
  - QUIET: wait for `quiet`, then go to SEND. This wait absorbs any menu dump still streaming from the device.
  - SEND:
    - Transmit 0x30+sel: start bit, 8 data bits, stop bit.
    - When the stop bit's 16th tick ends, clear the quiet counter and go to RESP.
  - RESP:
    - Each valid byte (stop bit high): `rx_byte_count`+1 (saturating), `rx_xor`^=byte, `last_byte`=byte.
    - Invalid stop bit: set `frame_err`. Counters are not updated.
    - On `quiet` → DONE. A reply of zero bytes is legal: `done` fires after IDLE_BITS bit times with count 0.
  - DONE: pulse `done` for one clock, clear `busy`, return to IDLE. Result outputs hold until the next accepted `start`.
- `start` while `busy` is ignored. It is not queued.
- Reset asserted mid-operation:
  - All state returns to reset values asynchronously.
  - `host_tx` goes high immediately. A truncated frame is acceptable.
- A byte completing in the same clock as the RESP→DONE transition is impossible, because `quiet` requires an idle RX.

## Timing
- One bit = 16*CLK_DIV clocks (864 at default). One frame = 10 bits (8640 clocks).
- `start` → `busy`: next rising edge.
- Line already idle for the whole wait: QUIET lasts IDLE_BITS*16 ticks (17280 clocks at default), ±1 tick for divider phase.
- `host_tx` start-bit falling edge follows within 1 tick of entering SEND.
- Reply byte → outputs updated: the clock after the stop-bit sample, at mid-stop-bit.
- Last reply stop bit → `done`: IDLE_BITS bit times plus up to 1 tick, plus 1 clock.

## Test plan
- Reset:
  - Stimulus: hold `rst_n`=0, then release.
  - Required: `host_tx`=1, `busy`=0, `done`=0, all results 0.
  - Reassert `rst_n` mid-SEND → `host_tx`=1 with no clock edge.
- Select 3, idle line:
  - Stimulus: `start` with `sel`=3.
  - Required: `busy`=1 next cycle.
  - After ~17280 clocks `host_tx` frames 0x33: low 864, then bits 1,1,0,0,1,1,0,0, then high 864.
- Three-byte reply:
  - Stimulus: device model sends 0x41, 0x42, 0x43, then stays silent.
  - Required: single `done` pulse about 17280 clocks after the last stop bit, with `rx_byte_count`=3, `rx_xor`=0x40, `last_byte`=0x43, `frame_err`=0.
- Busy line deferral:
  - Stimulus: device streams back-to-back bytes for 50 frames after `start`.
  - Required: `host_tx` stays high throughout and starts only after a 20-bit-time gap.
- Framing error:
  - Stimulus: reply 0x55 with stop bit low, then 0x10 valid.
  - Required: `frame_err`=1, `rx_byte_count`=1, `rx_xor`=0x10.
- Ignored start / empty reply:
  - Stimulus: second `start` pulse during RESP.
  - Required: no effect.
  - Stimulus: zero reply bytes.
  - Required: `done` with count 0, `rx_xor`=0.
